// File: rtl/dtmf_sequencer.sv
// dtmf_sequencer: queued DTMF dialler that plays buffered key codes as tone bursts and silent gaps.
// Optional DTMF_ABORT_EN adds an abort input that flushes the queue. Rev 1.0
`default_nettype none

module dtmf_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 840000,
  parameter int OFF_CYCLES = 840000,
  parameter int CNT_W      = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               digit_in,
  input  logic                     digit_valid,
  output logic                     digit_ready,
  input  logic [3:0]               row_tone,
  input  logic [3:0]               col_tone,
  output logic                     out_row,
  output logic                     out_column,
  output logic                     busy,
  output logic [3:0]               active_digit,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef DTMF_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_TMR   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       mem [DEPTH];
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;
  logic             abort_req;
  logic [1:0]       row_sel;
  logic [1:0]       col_sel;

`ifdef DTMF_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // An aborted cycle neither accepts a new digit nor pops one.
  assign push = digit_valid && digit_ready && !abort_req;
  assign busy = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    if (abort_req) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            state_next = TONE;
            timer_next = ON_LOAD;
          end
        end
        TONE: begin
          if (timer == '0) begin
            state_next = GAP;
            timer_next = OFF_LOAD;
          end else begin
            timer_next = timer - ONE_TMR;
          end
        end
        GAP: begin
          if (timer == '0) begin
            state_next = IDLE;
          end else begin
            timer_next = timer - ONE_TMR;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    count_next = fifo_count;
    if (abort_req) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = fifo_count + ONE_CNT;
        2'b01:   count_next = fifo_count - ONE_CNT;
        default: count_next = fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= digit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
    end
  end

  // Ready is registered from the next count, so a pop while full frees the slot one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count  <= '0;
      digit_ready <= 1'b1;
    end else begin
      fifo_count  <= count_next;
      digit_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow     <= 1'b0;
      active_digit <= 4'h0;
    end else begin
      if (digit_valid && !digit_ready) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        active_digit <= mem[rd_ptr];
      end
    end
  end

  always_comb begin
    row_sel = 2'd0;
    col_sel = 2'd0;
    case (active_digit)
      4'h1: begin row_sel = 2'd0; col_sel = 2'd0; end
      4'h2: begin row_sel = 2'd0; col_sel = 2'd1; end
      4'h3: begin row_sel = 2'd0; col_sel = 2'd2; end
      4'h4: begin row_sel = 2'd1; col_sel = 2'd0; end
      4'h5: begin row_sel = 2'd1; col_sel = 2'd1; end
      4'h6: begin row_sel = 2'd1; col_sel = 2'd2; end
      4'h7: begin row_sel = 2'd2; col_sel = 2'd0; end
      4'h8: begin row_sel = 2'd2; col_sel = 2'd1; end
      4'h9: begin row_sel = 2'd2; col_sel = 2'd2; end
      4'h0: begin row_sel = 2'd3; col_sel = 2'd1; end
      4'hE: begin row_sel = 2'd3; col_sel = 2'd0; end
      4'hF: begin row_sel = 2'd3; col_sel = 2'd2; end
      4'hA: begin row_sel = 2'd0; col_sel = 2'd3; end
      4'hB: begin row_sel = 2'd1; col_sel = 2'd3; end
      4'hC: begin row_sel = 2'd2; col_sel = 2'd3; end
      4'hD: begin row_sel = 2'd3; col_sel = 2'd3; end
      default: begin row_sel = 2'd0; col_sel = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort_req) begin
      out_row    <= 1'b0;
      out_column <= 1'b0;
    end else if (state == TONE) begin
      out_row    <= row_tone[row_sel];
      out_column <= col_tone[col_sel];
    end else begin
      out_row    <= 1'b0;
      out_column <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dtmf_sequencer.sv
// tb_dtmf_sequencer: directed, table-driven bench for dtmf_sequencer (DEPTH=4, ON=4, OFF=3).
`default_nettype none

module tb_dtmf_sequencer;

  localparam int DEPTH = 4;
  localparam int ON_C  = 4;
  localparam int OFF_C = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = 4'h0;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic [3:0] row_tone = 4'h0;
  logic [3:0] col_tone = 4'h0;
  logic       out_row;
  logic       out_column;
  logic       busy;
  logic [3:0] active_digit;
  logic [2:0] fifo_count;
  logic       overflow;
`ifdef DTMF_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] code;
    logic [3:0] rt;
    logic [3:0] ct;
    logic       exp_out;
  } vec_t;

  vec_t       vecs [32];
  logic [3:0] row_oh [16];
  logic [3:0] col_oh [16];
  int         rises [3];
  int         n_rise;
  logic       prev;

  dtmf_sequencer #(
    .DEPTH(DEPTH), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .row_tone(row_tone), .col_tone(col_tone),
    .out_row(out_row), .out_column(out_column), .busy(busy),
    .active_digit(active_digit), .fifo_count(fifo_count), .overflow(overflow)
`ifdef DTMF_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Keypad one-hot row/column per code 0..F
    row_oh = '{4'h8, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4,
               4'h4, 4'h4, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h8};
    col_oh = '{4'h2, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1,
               4'h2, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h4};
    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{code: 4'(i), rt: row_oh[i],  ct: col_oh[i],  exp_out: 1'b1};
      vecs[i + 16] = '{code: 4'(i), rt: ~row_oh[i], ct: ~col_oh[i], exp_out: 1'b0};
    end

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst out_row", {31'd0, out_row}, 0);
    check("rst out_column", {31'd0, out_column}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst digit_ready", {31'd0, digit_ready}, 1);
    check("rst fifo_count", {29'd0, fifo_count}, 0);
    check("rst overflow", {31'd0, overflow}, 0);
    check("rst active_digit", {28'd0, active_digit}, 0);

    // Single key 5: exact tone window and gap
    row_tone = 4'b0010;
    col_tone = 4'b0010;
    digit_in = 4'h5;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check("single queued", {29'd0, fifo_count}, 1);
    check("single busy", {31'd0, busy}, 1);
    tick();
    check("single active", {28'd0, active_digit}, 5);
    check("single entry out", {30'd0, out_row, out_column}, 0);
    check("single popped", {29'd0, fifo_count}, 0);
    for (int k = 0; k < ON_C; k++) begin
      tick();
      check("single tone", {30'd0, out_row, out_column}, 3);
    end
    for (int k = 0; k < OFF_C; k++) begin
      if (k == OFF_C - 1) check("single busy gap", {31'd0, busy}, 1);
      tick();
      check("single gap", {30'd0, out_row, out_column}, 0);
    end
    check("single busy done", {31'd0, busy}, 0);
    check("single active kept", {28'd0, active_digit}, 5);

    // Mapping sweep, driven from the vector table
    for (int v = 0; v < 32; v++) begin
      row_tone = vecs[v].rt;
      col_tone = vecs[v].ct;
      digit_in = vecs[v].code;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      tick();
      check("map active", {28'd0, active_digit}, {28'd0, vecs[v].code});
      for (int k = 0; k < ON_C; k++) begin
        tick();
        check("map out_row", {31'd0, out_row}, {31'd0, vecs[v].exp_out});
        check("map out_column", {31'd0, out_column}, {31'd0, vecs[v].exp_out});
      end
      for (int k = 0; k < OFF_C; k++) begin
        tick();
        check("map gap", {30'd0, out_row, out_column}, 0);
      end
      check("map idle", {31'd0, busy}, 0);
    end

    // Back-to-back 1,2,3: rising edges 8 cycles apart
    row_tone = 4'hF;
    col_tone = 4'hF;
    n_rise = 0;
    prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      digit_valid = (c < 3);
      digit_in = 4'(c + 1);
      tick();
      if (out_row && !prev && n_rise < 3) begin
        rises[n_rise] = c;
        n_rise++;
      end
      prev = out_row;
    end
    digit_valid = 1'b0;
    check("b2b rise count", n_rise, 3);
    if (n_rise == 3) begin
      check("b2b spacing 1-2", rises[1] - rises[0], 8);
      check("b2b spacing 2-3", rises[2] - rises[1], 8);
    end
    check("b2b last active", {28'd0, active_digit}, 3);
    check("b2b idle", {31'd0, busy}, 0);

    // Overflow while a tone plays
    digit_in = 4'h7;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      digit_in = 4'(i);
      digit_valid = 1'b1;
      tick();
    end
    digit_valid = 1'b0;
    check("ovf full ready", {31'd0, digit_ready}, 0);
    check("ovf full count", {29'd0, fifo_count}, 4);
    check("ovf not yet", {31'd0, overflow}, 0);
    digit_in = 4'h9;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check("ovf set", {31'd0, overflow}, 1);
    check("ovf dropped", {29'd0, fifo_count}, 4);
    wait_idle(100);
    check("ovf sticky", {31'd0, overflow}, 1);
    check("ovf last played", {28'd0, active_digit}, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf cleared by rst", {31'd0, overflow}, 0);

    // Reset mid-tone discards the queue
    for (int i = 0; i < 3; i++) begin
      digit_in = 4'(i + 1);
      digit_valid = 1'b1;
      tick();
    end
    digit_valid = 1'b0;
    check("midrst tone on", {30'd0, out_row, out_column}, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out", {30'd0, out_row, out_column}, 0);
    check("midrst count", {29'd0, fifo_count}, 0);
    check("midrst busy", {31'd0, busy}, 0);
    check("midrst active", {28'd0, active_digit}, 0);
    for (int k = 0; k < 5; k++) tick();
    check("midrst stays idle", {30'd0, busy, out_row}, 0);

`ifdef DTMF_ABORT_EN
    // Abort during a tone with three digits queued; same-cycle push is dropped
    for (int i = 0; i < 4; i++) begin
      digit_in = 4'(i + 1);
      digit_valid = 1'b1;
      tick();
    end
    check("abort queued", {29'd0, fifo_count}, 3);
    check("abort tone on", {30'd0, out_row, out_column}, 3);
    digit_in = 4'h6;
    digit_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    digit_valid = 1'b0;
    check("abort out", {30'd0, out_row, out_column}, 0);
    check("abort count", {29'd0, fifo_count}, 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort active kept", {28'd0, active_digit}, 1);
    check("abort ready", {31'd0, digit_ready}, 1);
    for (int k = 0; k < 4; k++) tick();
    check("abort push dropped", {30'd0, busy, out_row}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
